// File: rtl/mem_pe_pkg.sv
// Shared defaults and FSM encoding for the Mem_PE round-robin access controller.
package mem_pe_pkg;

    localparam int WORDSIZE_DEF = 16;
    localparam int MEMSIZE_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Index width for a requester number, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_pe_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping.
module rr_arbiter
    import mem_pe_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!valid_o && req_i[(int'(ptr_i) + off) % NREQ]) begin
                valid_o   = 1'b1;
                gnt_o[(int'(ptr_i) + off) % NREQ] = 1'b1;
                gnt_idx_o = IW'((int'(ptr_i) + off) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mem_pe_arb.sv
// Shares the single-port Mem_PE word memory between NREQ requesters, one
// transaction per two cycles, granting in round-robin order.
module mem_pe_arb
    import mem_pe_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int MEMSIZE  = MEMSIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*MEMSIZE-1:0]  req_addr,
    input  logic [NREQ*WORDSIZE-1:0] req_wdata,
    output logic [NREQ-1:0]          ack,
    output logic [WORDSIZE-1:0]      rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [MEMSIZE-1:0]       mem_addr,
    output logic [WORDSIZE-1:0]      mem_wdata,
    input  logic [WORDSIZE-1:0]      mem_rdata
);

    localparam int IW = idx_width(NREQ);

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       win_id_q, win_id_d;
    logic                op_q, op_d;
    logic [MEMSIZE-1:0]  addr_q, addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;

    logic [NREQ-1:0]     win_oh;
    logic [NREQ-1:0]     req_elig;
    logic [NREQ-1:0]     gnt_oh;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_valid;
    logic                grant;

    always_comb begin
        win_oh           = '0;
        win_oh[win_id_q] = 1'b1;
    end

    // The requester being acknowledged is masked so it cannot be served twice.
    assign req_elig = (state_q == RESP) ? (req & ~win_oh) : req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i     (req_elig),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .valid_o   (gnt_valid)
    );

    assign grant = gnt_valid && (state_q != ACCESS);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_id_d = win_id_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE, RESP: state_d = grant ? ACCESS : IDLE;
            ACCESS:     state_d = RESP;
            default:    state_d = IDLE;
        endcase
        if (grant) begin
            win_id_d = gnt_idx;
            rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            op_d     = |(req_we & gnt_oh);
            addr_d   = '0;
            wdata_d  = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_oh[i]) begin
                    addr_d  = addr_d  | req_addr[i*MEMSIZE +: MEMSIZE];
                    wdata_d = wdata_d | req_wdata[i*WORDSIZE +: WORDSIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_id_q <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_id_q <= win_id_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack       = (state_q == RESP) ? win_oh : '0;
    assign rdata     = (state_q == RESP && !op_q) ? mem_rdata : '0;

endmodule
